// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux_if
// Brief   : Digit/anode bundle between timekeeping logic and the display scanner.
// Revision: 1.0 - initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   an;
    logic [3:0]              digit;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output digits, digit_en, dp_in, lz_en,
        input  an, digit, dp, frame_tick
    );

    modport slave (
        input  digits, digit_en, dp_in, lz_en,
        output an, digit, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux
// Brief   : Time-multiplexed 7-segment digit scanner with blanking guard,
//           per-frame input shadowing and leading-zero suppression.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    seg7_scan_mux_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_sh_q;
    logic [NUM_DIGITS-1:0]   en_sh_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic                    lz_sh_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              digit_q, digit_d;
    logic                    dp_q, dp_d;
    logic                    tick_q, tick_d;

    logic                    frame_start;
    logic                    in_blank;
    logic                    lit;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;

    assign frame_start = (cnt_q == '0) && (idx_q == '0);
    assign in_blank    = (cnt_q < CNT_BLANK);
    assign cur_digit   = dig_sh_q[{idx_q, 2'b00} +: 4];
    assign lit         = en_sh_q[idx_q] && !supp[idx_q];

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A zero run from the top digit down stays suppressed until a non-zero
    // digit or a lit decimal point breaks it; digit 0 is always shown.
    always_comb begin
        supp     = '0;
        zero_run = lz_sh_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (dig_sh_q[4*i +: 4] == 4'd0) && !dp_sh_q[i];
            supp[i]  = zero_run;
        end
    end

    always_comb begin
        an_d    = '1;
        dp_d    = 1'b1;
        digit_d = digit_q;
        tick_d  = frame_start;
        if (!in_blank) begin
            digit_d = cur_digit;
            if (lit) begin
                an_d[idx_q] = 1'b0;
                dp_d        = ~dp_sh_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            dig_sh_q <= '0;
            en_sh_q  <= '0;
            dp_sh_q  <= '0;
            lz_sh_q  <= 1'b0;
            an_q     <= '1;
            digit_q  <= 4'd0;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
            if (frame_start) begin
                dig_sh_q <= bus.digits;
                en_sh_q  <= bus.digit_en;
                dp_sh_q  <= bus.dp_in;
                lz_sh_q  <= bus.lz_en;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.digit      = digit_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;
endmodule
`default_nettype wire
